// File: rtl/bin_cnt_seq_pkg.sv
// Shared definitions for the binary counter sequencer: state encoding,
// reload counter width and prescaler counter sizing.
package bin_cnt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        CLR  = 2'd3
    } state_e;

    localparam int RELOADS_W = 8;

    // A prescale of 1 still needs a 1-bit counter so the tick compare is legal.
    function automatic int pcnt_width(input int presc);
        return (presc > 1) ? $clog2(presc) : 1;
    endfunction

endpackage

// File: rtl/bin_cnt_seq_presc_tick.sv
// Prescaler: counts 0..PRESC-1 while enabled and flags the last count as tick.
module bin_cnt_seq_presc_tick
    import bin_cnt_seq_pkg::*;
#(
    parameter int PRESC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = pcnt_width(PRESC);
    localparam logic [W-1:0] LAST = W'(PRESC - 1);

    logic [W-1:0] pcnt_q;
    logic [W-1:0] pcnt_d;

    assign tick_o = (pcnt_q == LAST);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = tick_o ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/bin_cnt_seq.sv
// Sequencer for the universal binary counter: loads an initial value, steps the
// counter at a prescaled rate and stops or reloads on the terminal count.
module bin_cnt_seq
    import bin_cnt_seq_pkg::*;
#(
    parameter int N     = 3,
    parameter int PRESC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 dir,
    input  logic                 mode,
    input  logic [N-1:0]         init,
    input  logic                 max_tick,
    input  logic                 min_tick,
    output logic                 syn_clr,
    output logic                 load,
    output logic                 en,
    output logic                 up,
    output logic [N-1:0]         d,
    output logic                 busy,
    output logic                 done,
    output logic [RELOADS_W-1:0] reloads
);

    state_e               state_q, state_d;
    logic [N-1:0]         init_q, init_d;
    logic                 dir_q, dir_d;
    logic                 mode_q, mode_d;
    logic                 done_q, done_d;
    logic [RELOADS_W-1:0] reloads_q, reloads_d;
    logic                 tick;
    logic                 term;

    function automatic logic [RELOADS_W-1:0] sat_inc(input logic [RELOADS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Held clear outside RUN, so the LOAD cycle restarts the prescale window.
    bin_cnt_seq_presc_tick #(
        .PRESC (PRESC)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_q != RUN),
        .en_i   (state_q == RUN),
        .tick_o (tick)
    );

    assign term = dir_q ? max_tick : min_tick;

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        reloads_d = reloads_q;
        syn_clr   = 1'b0;
        load      = 1'b0;
        en        = 1'b0;
        up        = 1'b0;
        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = CLR;
                end else if (start) begin
                    init_d    = init;
                    dir_d     = dir;
                    mode_d    = mode;
                    reloads_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                up      = dir_q;
                state_d = stop ? CLR : RUN;
            end
            RUN: begin
                up = dir_q;
                // Counter strobes ignore stop; stop only redirects state and kills done.
                if (tick) begin
                    if (!term) begin
                        en = 1'b1;
                    end else if (mode_q) begin
                        load = 1'b1;
                        if (!stop) begin
                            done_d    = 1'b1;
                            reloads_d = sat_inc(reloads_q);
                        end
                    end else if (!stop) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (stop) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                syn_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            init_q    <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            reloads_q <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            reloads_q <= reloads_d;
        end
    end

    assign d       = init_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign reloads = reloads_q;

endmodule

// File: tb/tb_bin_cnt_seq.sv
// Bench for bin_cnt_seq: two instances (PRESC=1 and PRESC=4) each driving a
// behavioural 3-bit universal counter; counter strobes are scoreboarded.
module tb_bin_cnt_seq;

    localparam int EV_CLR  = 1;
    localparam int EV_LOAD = 2;
    localparam int EV_EN   = 3;
    localparam int EV_DONE = 4;

    logic clk;
    logic reset;

    logic [1:0]       start_s, stop_s, dir_s, mode_s;
    logic [1:0][2:0]  init_s;
    logic [1:0]       syn_clr_s, load_s, en_s, up_s, busy_s, done_s;
    logic [1:0][2:0]  d_s;
    logic [1:0][7:0]  reloads_s;
    logic [1:0][2:0]  cq;
    logic [1:0]       maxt, mint;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt0 = 0;
    int en_cnt1 = 0;
    int exp0[$];
    int exp1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bin_cnt_seq #(
            .N     (3),
            .PRESC ((g == 0) ? 1 : 4)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start_s[g]),
            .stop     (stop_s[g]),
            .dir      (dir_s[g]),
            .mode     (mode_s[g]),
            .init     (init_s[g]),
            .max_tick (maxt[g]),
            .min_tick (mint[g]),
            .syn_clr  (syn_clr_s[g]),
            .load     (load_s[g]),
            .en       (en_s[g]),
            .up       (up_s[g]),
            .d        (d_s[g]),
            .busy     (busy_s[g]),
            .done     (done_s[g]),
            .reloads  (reloads_s[g])
        );
    end

    // Behavioural universal counter, one per instance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cq <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (syn_clr_s[k])   cq[k] <= 3'd0;
                else if (load_s[k]) cq[k] <= d_s[k];
                else if (en_s[k])   cq[k] <= up_s[k] ? cq[k] + 3'd1 : cq[k] - 3'd1;
            end
        end
    end

    always_comb begin
        maxt = '0;
        mint = '0;
        for (int k = 0; k < 2; k++) begin
            maxt[k] = (cq[k] == 3'd7);
            mint[k] = (cq[k] == 3'd0);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int enc(input int kind, input int val);
        return (kind << 12) | val;
    endfunction

    task automatic push_ev(input int k, input int kind, input int val);
        if (k == 0) exp0.push_back(enc(kind, val));
        else        exp1.push_back(enc(kind, val));
    endtask

    task automatic mon_ev(input int k, input int kind, input int val);
        int e;
        if (k == 0) begin
            if (exp0.size() == 0) e = -1;
            else e = exp0.pop_front();
        end else begin
            if (exp1.size() == 0) e = -1;
            else e = exp1.pop_front();
        end
        chk($sformatf("ev%0d_kind%0d", k, kind), enc(kind, val), e);
    endtask

    // Monitor: every counter strobe or done pulse is matched against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (syn_clr_s[k]) mon_ev(k, EV_CLR, 0);
                if (load_s[k])    mon_ev(k, EV_LOAD, int'(d_s[k]));
                if (en_s[k]) begin
                    mon_ev(k, EV_EN, int'(up_s[k]) * 8 + int'(cq[k]));
                    if (k == 0) en_cnt0++;
                    else        en_cnt1++;
                end
                if (done_s[k])    mon_ev(k, EV_DONE, int'(reloads_s[k]) * 8 + int'(cq[k]));
                if ((syn_clr_s[k] | load_s[k] | en_s[k]) == 1'b1)
                    chk($sformatf("onehot%0d", k),
                        int'(syn_clr_s[k]) + int'(load_s[k]) + int'(en_s[k]), 1);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic issue(input int k, input logic [2:0] iv, input logic dv, input logic mv);
        init_s[k]  = iv;
        dir_s[k]   = dv;
        mode_s[k]  = mv;
        start_s[k] = 1'b1;
        step(1);
        start_s[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        while (busy_s[k] && n < budget) begin
            step(1);
            n++;
        end
        chk($sformatf("idle_timeout%0d", k), int'(busy_s[k]), 0);
    endtask

    initial begin
        int base;
        start_s = '0; stop_s = '0; dir_s = '0; mode_s = '0; init_s = '0;
        reset = 1'b1;
        step(3);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",    int'(busy_s[k]),    0);
            chk("rst_done",    int'(done_s[k]),    0);
            chk("rst_reloads", int'(reloads_s[k]), 0);
            chk("rst_ctrl",    int'({syn_clr_s[k], load_s[k], en_s[k], up_s[k]}), 0);
            chk("rst_d",       int'(d_s[k]),       0);
        end
        reset = 1'b0;
        step(2);

        // One-shot up from 5 with PRESC=1.
        base = en_cnt0;
        push_ev(0, EV_LOAD, 5);
        push_ev(0, EV_EN, 8 + 5);
        push_ev(0, EV_EN, 8 + 6);
        push_ev(0, EV_DONE, 7);
        issue(0, 3'd5, 1'b1, 1'b0);
        chk("t1_load_c1", int'(load_s[0]), 1);
        step(4);
        chk("t1_done_c5", int'(done_s[0]), 1);
        chk("t1_busy_c5", int'(busy_s[0]), 0);
        chk("t1_q_c5",    int'(cq[0]),     7);
        step(2);
        chk("t1_q_hold",  int'(cq[0]),     7);
        chk("t1_en_cnt",  en_cnt0 - base,  2);

        // One-shot down from 2 with PRESC=4.
        push_ev(1, EV_LOAD, 2);
        push_ev(1, EV_EN, 2);
        push_ev(1, EV_EN, 1);
        push_ev(1, EV_DONE, 0);
        issue(1, 3'd2, 1'b0, 1'b0);
        step(3);
        chk("t2_en_c4", int'(en_s[1]), 0);
        step(1);
        chk("t2_en_c5", int'(en_s[1]), 1);
        wait_idle(1, 40);
        step(2);
        chk("t2_q_end", int'(cq[1]), 0);

        // Auto-reload from 6, long enough to saturate reloads, then stop on a terminal tick.
        push_ev(0, EV_LOAD, 6);
        push_ev(0, EV_EN, 8 + 6);
        for (int i = 1; i <= 260; i++) begin
            push_ev(0, EV_LOAD, 6);
            push_ev(0, EV_EN, 8 + 6);
            push_ev(0, EV_DONE, ((i > 255) ? 255 : i) * 8 + 6);
        end
        push_ev(0, EV_LOAD, 6);
        push_ev(0, EV_CLR, 0);
        issue(0, 3'd6, 1'b1, 1'b1);
        step(3);
        chk("t3_reloads_c4", int'(reloads_s[0]), 1);
        step(2 * 260 + 2 - 3);
        chk("t3_term_c", int'(cq[0]), 7);
        stop_s[0] = 1'b1;
        step(1);
        stop_s[0] = 1'b0;
        chk("t3_clr",     int'(syn_clr_s[0]), 1);
        chk("t3_nodone",  int'(done_s[0]),    0);
        step(1);
        chk("t3_q0",      int'(cq[0]),        0);
        chk("t3_busy",    int'(busy_s[0]),    0);
        chk("t3_reloads", int'(reloads_s[0]), 255);

        // Stop mid-RUN on PRESC=4, with an ignored start while busy.
        push_ev(1, EV_LOAD, 3);
        push_ev(1, EV_EN, 8 + 3);
        push_ev(1, EV_CLR, 0);
        issue(1, 3'd3, 1'b1, 1'b0);
        step(2);
        init_s[1] = 3'd7; dir_s[1] = 1'b0; start_s[1] = 1'b1;
        step(1);
        start_s[1] = 1'b0;
        step(3);
        stop_s[1] = 1'b1;
        step(1);
        stop_s[1] = 1'b0;
        chk("t4_clr",   int'(syn_clr_s[1]), 1);
        chk("t4_d",     int'(d_s[1]),       3);
        step(1);
        chk("t4_q0",    int'(cq[1]),        0);
        chk("t4_busy",  int'(busy_s[1]),    0);

        // start and stop together in IDLE: clear only, nothing latched.
        push_ev(0, EV_CLR, 0);
        init_s[0] = 3'd1; start_s[0] = 1'b1; stop_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0; stop_s[0] = 1'b0;
        chk("t5_load", int'(load_s[0]), 0);
        chk("t5_busy", int'(busy_s[0]), 1);
        step(1);
        chk("t5_idle",    int'(busy_s[0]),    0);
        chk("t5_reloads", int'(reloads_s[0]), 255);
        chk("t5_d",       int'(d_s[0]),       6);

        // init already terminal: no steps, immediate done.
        base = en_cnt0;
        push_ev(0, EV_LOAD, 7);
        push_ev(0, EV_DONE, 7);
        issue(0, 3'd7, 1'b1, 1'b0);
        step(2);
        chk("t6_done",    int'(done_s[0]),    1);
        chk("t6_reloads", int'(reloads_s[0]), 0);
        chk("t6_en_cnt",  en_cnt0 - base,     0);

        // Async reset mid-RUN while en is high.
        push_ev(1, EV_LOAD, 2);
        issue(1, 3'd2, 1'b1, 1'b1);
        step(4);
        chk("t7_en_pre", int'(en_s[1]), 1);
        #1 reset = 1'b1;
        #1;
        chk("t7_busy", int'(busy_s[1]), 0);
        chk("t7_en",   int'(en_s[1]),   0);
        chk("t7_load", int'(load_s[1]), 0);
        chk("t7_done", int'(done_s[1]), 0);
        step(2);
        reset = 1'b0;
        step(2);
        chk("t7_idle", int'(busy_s[1]), 0);
        chk("t7_d",    int'(d_s[1]),    0);

        chk("q0_empty", exp0.size(), 0);
        chk("q1_empty", exp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
